// File: rtl/ua_pkg.sv
// Shared definitions for the UART receive packet controller.
// Holds the parser state encoding, the default frame start marker and
// the helper that sizes the payload buffer address from its depth.
package ua_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_LEN  = 3'd1;
   localparam state_t ST_DATA = 3'd2;
   localparam state_t ST_CSUM = 3'd3;
   localparam state_t ST_HOLD = 3'd4;

   localparam logic [7:0] UA_SYNC_BYTE_DEFAULT = 8'hA5;

   // Address width of a buffer holding max_len bytes (at least 1 bit).
   function automatic int ua_addr_width(input int max_len);
      return (max_len <= 2) ? 1 : $clog2(max_len);
   endfunction

endpackage

// File: rtl/ua_tick_gen.sv
// Sample-tick divider shared by the UART receiver and transmitter.
// Produces a registered one-clock pulse every SAMPLE_DIV clocks while run_i
// is high; dropping run_i clears the divider and silences the tick.
module ua_tick_gen #(
   parameter int SAMPLE_DIV = 27
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run_i,
   output logic tick_o
);

   localparam int DW = (SAMPLE_DIV <= 2) ? 1 : $clog2(SAMPLE_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

   logic [DW-1:0] div_q, div_d;
   logic          tick_q;

   // Next divider value: wrap at the last count, hold at zero while stopped.
   always_comb begin
      div_d = '0;
      if (run_i && (div_q != DIV_LAST)) begin
         div_d = div_q + 1'b1;
      end
   end

   // Divider register and tick, which is high while the divider sits at its last count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= run_i && (div_d == DIV_LAST);
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/ua_rx_packet_ctrl.sv
// UART receive packet controller: generates the receiver sample tick, turns
// the receiver ready edge into a byte strobe and parses SYNC/LEN/payload
// frames into a local buffer held until the host acknowledges it.
// Build option: define UA_RX_CSUM_EN to expect a trailing XOR checksum byte.
module ua_rx_packet_ctrl
   import ua_pkg::*;
#(
   parameter int         SAMPLE_DIV    = 27,
   parameter int         MAX_LEN       = 16,
   parameter logic [7:0] SYNC_BYTE     = UA_SYNC_BYTE_DEFAULT,
   parameter int         TIMEOUT_TICKS = 1024,
   localparam int        AW            = ua_addr_width(MAX_LEN)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   output logic          rx_enable,
   input  logic [7:0]    rx_byte,
   input  logic          rx_byte_rdy,
   output logic          pkt_valid,
   output logic [AW:0]   pkt_len,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   input  logic          pkt_ack,
   output logic          pkt_err,
   output logic          overrun
);

   localparam int TW = (TIMEOUT_TICKS <= 2) ? 1 : $clog2(TIMEOUT_TICKS);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);

   state_t        state_q, state_d;
   logic [AW:0]   len_q, len_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [TW-1:0] to_q, to_d;
   logic          err_q, err_d;
   logic          ovr_q, ovr_d;
   logic          rdy_q, edge1_q, edge2_q;
   logic          byte_stb, active, last_byte, len_ok, timeout_hit, buf_we;
   logic [7:0]    buf_q [MAX_LEN];
`ifdef UA_RX_CSUM_EN
   logic [7:0]    csum_q, csum_d;
`endif

   ua_tick_gen #(
      .SAMPLE_DIV (SAMPLE_DIV)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .run_i  (run),
      .tick_o (rx_enable)
   );

   // Delay the ready rising edge by two clocks so rx_byte has settled when sampled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q   <= 1'b1;
         edge1_q <= 1'b0;
         edge2_q <= 1'b0;
      end else begin
         rdy_q   <= rx_byte_rdy;
         edge1_q <= rx_byte_rdy & ~rdy_q;
         edge2_q <= edge1_q;
      end
   end

   assign byte_stb    = edge2_q & run;
   assign active      = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
   assign last_byte   = ({1'b0, waddr_q} == (len_q - 1'b1));
   assign len_ok      = (rx_byte != 8'd0) && ({1'b0, rx_byte} <= 9'(MAX_LEN));
   assign timeout_hit = active && !byte_stb && rx_enable && (to_q == TO_LAST);

   // Frame parser: next state, length, write address, timeout and status flags.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      waddr_d = waddr_q;
      err_d   = 1'b0;
      ovr_d   = ovr_q;
      buf_we  = 1'b0;
      to_d    = '0;
`ifdef UA_RX_CSUM_EN
      csum_d  = csum_q;
`endif
      if (active && !byte_stb) begin
         to_d = rx_enable ? to_q + 1'b1 : to_q;
      end
      case (state_q)
         ST_IDLE: begin
            if (byte_stb && (rx_byte == SYNC_BYTE)) begin
               state_d = ST_LEN;
            end
         end
         ST_LEN: begin
            if (byte_stb) begin
               if (len_ok) begin
                  len_d   = (AW+1)'({1'b0, rx_byte});
                  waddr_d = '0;
`ifdef UA_RX_CSUM_EN
                  csum_d  = rx_byte;
`endif
                  state_d = ST_DATA;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (byte_stb) begin
               buf_we  = 1'b1;
               waddr_d = waddr_q + 1'b1;
`ifdef UA_RX_CSUM_EN
               csum_d  = csum_q ^ rx_byte;
               if (last_byte) begin
                  state_d = ST_CSUM;
               end
`else
               if (last_byte) begin
                  state_d = ST_HOLD;
               end
`endif
            end
         end
`ifdef UA_RX_CSUM_EN
         ST_CSUM: begin
            if (byte_stb) begin
               if (rx_byte == csum_q) begin
                  state_d = ST_HOLD;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
`endif
         ST_HOLD: begin
            if (pkt_ack) begin
               ovr_d   = 1'b0;
               state_d = ST_IDLE;
            end else if (byte_stb) begin
               ovr_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (timeout_hit) begin
         err_d   = 1'b1;
         state_d = ST_IDLE;
      end
      if (!run && active) begin
         err_d   = 1'b0;
         state_d = ST_IDLE;
      end
   end

   // Parser state and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         waddr_q <= '0;
         to_q    <= '0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         waddr_q <= waddr_d;
         to_q    <= to_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
      end
   end

`ifdef UA_RX_CSUM_EN
   // Running XOR over LEN and the payload bytes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end
`endif

   // Payload buffer; contents are kept across packets and need no reset.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         buf_q[waddr_q] <= rx_byte;
      end
   end

   assign pkt_valid = (state_q == ST_HOLD);
   assign pkt_len   = pkt_valid ? len_q : '0;
   assign rd_data   = buf_q[rd_addr];
   assign pkt_err   = err_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_ua_rx_packet_ctrl.sv
// Testbench for ua_rx_packet_ctrl. Bytes are delivered by toggling the
// receiver ready line; packets and errors are compared against expected
// events derived from the frame rules. Honors UA_RX_CSUM_EN like the design.
module tb_ua_rx_packet_ctrl;

   localparam int SAMPLE_DIV    = 4;
   localparam int MAX_LEN       = 16;
   localparam int TIMEOUT_TICKS = 8;
   localparam int AW            = 4;

   typedef struct {
      bit                     isErr;
      int                     len;
      logic [8*MAX_LEN-1:0]   data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          run = 1'b0;
   logic          rx_enable;
   logic [7:0]    rx_byte = 8'h00;
   logic          rx_byte_rdy = 1'b1;
   logic          pkt_valid;
   logic [AW:0]   pkt_len;
   logic [AW-1:0] rd_addr = '0;
   logic [7:0]    rd_data;
   logic          pkt_ack = 1'b0;
   logic          pkt_err;
   logic          overrun;

   int   checks = 0;
   int   failures = 0;
   exp_t expQ[$];
   bit   pktChecked = 1'b0;
   logic [8*MAX_LEN-1:0] heldData = '0;
   int   heldLen = 0;

   ua_rx_packet_ctrl #(
      .SAMPLE_DIV    (SAMPLE_DIV),
      .MAX_LEN       (MAX_LEN),
      .SYNC_BYTE     (8'hA5),
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .rx_enable   (rx_enable),
      .rx_byte     (rx_byte),
      .rx_byte_rdy (rx_byte_rdy),
      .pkt_valid   (pkt_valid),
      .pkt_len     (pkt_len),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .pkt_ack     (pkt_ack),
      .pkt_err     (pkt_err),
      .overrun     (overrun)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // One byte through the receiver handshake; optionally raise pkt_ack in the strobe clock.
   task automatic applyStimulus(input logic [7:0] b, input bit ackSame);
      @(negedge clk);
      rx_byte = b;
      rx_byte_rdy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rx_byte_rdy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      if (ackSame) pkt_ack = 1'b1;
      @(negedge clk);
      pkt_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic pushErr();
      exp_t e;
      e.isErr = 1'b1;
      e.len = 0;
      e.data = '0;
      expQ.push_back(e);
   endtask

   task automatic waitPkt();
      int n = 0;
      while (!pktChecked && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput("pkt_arrived", int'(pktChecked), 1);
   endtask

   task automatic ackPkt();
      @(negedge clk);
      pkt_ack = 1'b1;
      @(negedge clk);
      pkt_ack = 1'b0;
      checkOutput("ack_valid_low", int'(pkt_valid), 0);
      checkOutput("ack_overrun_low", int'(overrun), 0);
   endtask

   // Full valid frame; expected packet is the payload itself.
   task automatic sendGood(input int len, input logic [8*MAX_LEN-1:0] data);
      exp_t e;
      logic [7:0] x;
      e.isErr = 1'b0;
      e.len = len;
      e.data = data;
      pktChecked = 1'b0;
      expQ.push_back(e);
      x = 8'(len);
      applyStimulus(8'hA5, 1'b0);
      applyStimulus(8'(len), 1'b0);
      for (int i = 0; i < len; i++) begin
         applyStimulus(data[i*8 +: 8], 1'b0);
         x = x ^ data[i*8 +: 8];
      end
`ifdef UA_RX_CSUM_EN
      applyStimulus(x, 1'b0);
`endif
      waitPkt();
   endtask

   task automatic sendBadCsum(input int len, input logic [8*MAX_LEN-1:0] data, input logic [7:0] flip);
      logic [7:0] x;
      pushErr();
      x = 8'(len);
      applyStimulus(8'hA5, 1'b0);
      applyStimulus(8'(len), 1'b0);
      for (int i = 0; i < len; i++) begin
         applyStimulus(data[i*8 +: 8], 1'b0);
         x = x ^ data[i*8 +: 8];
      end
      applyStimulus(x ^ flip, 1'b0);
   endtask

   task automatic drainQueue();
      int n = 0;
      while (expQ.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("queue_drained", expQ.size(), 0);
   endtask

   function automatic logic [8*MAX_LEN-1:0] randData();
      logic [8*MAX_LEN-1:0] d;
      for (int i = 0; i < MAX_LEN; i++) d[i*8 +: 8] = 8'($urandom_range(0, 255));
      return d;
   endfunction

   // Observer: pops an expected event whenever the DUT reports an error or a new packet.
   initial begin
      bit   validPrev;
      bit   ovrPrev;
      exp_t e;
      validPrev = 1'b0;
      ovrPrev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            validPrev = 1'b0;
            ovrPrev = 1'b0;
            continue;
         end
         if (pkt_err) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_err", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("event_is_err", 1, int'(e.isErr));
               checkOutput("err_valid_low", int'(pkt_valid), 0);
            end
         end
         if (pkt_valid && !validPrev) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_pkt", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("event_is_err", 0, int'(e.isErr));
               if (!e.isErr) begin
                  checkOutput("pkt_len", int'(pkt_len), e.len);
                  for (int i = 0; i < e.len; i++) begin
                     rd_addr = AW'(i);
                     #1;
                     checkOutput("rd_data", int'(rd_data), int'(e.data[i*8 +: 8]));
                  end
                  heldData = e.data;
                  heldLen = e.len;
               end
            end
            pktChecked = 1'b1;
         end
         if (overrun && !ovrPrev) begin
            for (int i = 0; i < heldLen; i++) begin
               rd_addr = AW'(i);
               #1;
               checkOutput("buf_after_overrun", int'(rd_data), int'(heldData[i*8 +: 8]));
            end
         end
         validPrev = pkt_valid;
         ovrPrev = overrun;
      end
   end

   // Main sequence: reset, tick, directed frames, random frames, reset mid-frame.
   initial begin
      logic [8*MAX_LEN-1:0] d;
      int cnt;
      int last;
      int kind;
      int len;
      logic [7:0] g;

      #1;
      checkOutput("rst_rx_enable", int'(rx_enable), 0);
      checkOutput("rst_pkt_valid", int'(pkt_valid), 0);
      checkOutput("rst_pkt_len", int'(pkt_len), 0);
      checkOutput("rst_pkt_err", int'(pkt_err), 0);
      checkOutput("rst_overrun", int'(overrun), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("tick_idle", int'(rx_enable), 0);

      run = 1'b1;
      cnt = 0;
      last = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rx_enable) begin
            cnt++;
            if (last >= 0) checkOutput("tick_period", i - last, SAMPLE_DIV);
            last = i;
         end
      end
      checkOutput("tick_count", cnt, 40 / SAMPLE_DIV);
      run = 1'b0;
      @(negedge clk);
      checkOutput("tick_stop", int'(rx_enable), 0);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rx_enable) cnt++;
      end
      checkOutput("tick_stopped_count", cnt, 0);
      run = 1'b1;

      d = '0;
      d[7:0] = 8'h11;
      d[15:8] = 8'h22;
      d[23:16] = 8'h33;
      sendGood(3, d);
      ackPkt();

`ifdef UA_RX_CSUM_EN
      d = '0;
      d[7:0] = 8'h10;
      d[15:8] = 8'h20;
      sendBadCsum(2, d, 8'h32);
      drainQueue();
      d[7:0] = 8'h44;
      sendGood(2, d);
      ackPkt();
`endif

      pushErr();
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h7E, 1'b0);
      applyStimulus(8'hA5, 1'b0);
      applyStimulus(8'h00, 1'b0);
      pushErr();
      applyStimulus(8'hA5, 1'b0);
      applyStimulus(8'(MAX_LEN + 1), 1'b0);
      drainQueue();

      d = '0;
      d[7:0] = 8'hAB;
      d[15:8] = 8'hCD;
      sendGood(2, d);
      applyStimulus(8'h99, 1'b0);
      checkOutput("overrun_set", int'(overrun), 1);
      checkOutput("overrun_valid", int'(pkt_valid), 1);
      checkOutput("overrun_len", int'(pkt_len), 2);
      applyStimulus(8'h5A, 1'b1);
      checkOutput("race_valid", int'(pkt_valid), 0);
      checkOutput("race_overrun", int'(overrun), 0);
      checkOutput("race_len", int'(pkt_len), 0);

      pushErr();
      applyStimulus(8'hA5, 1'b0);
      applyStimulus(8'h02, 1'b0);
      applyStimulus(8'hAA, 1'b0);
      repeat (TIMEOUT_TICKS * SAMPLE_DIV + 20) @(negedge clk);
      checkOutput("timeout_queue", expQ.size(), 0);
      checkOutput("timeout_valid", int'(pkt_valid), 0);

      applyStimulus(8'hA5, 1'b0);
      applyStimulus(8'h02, 1'b0);
      applyStimulus(8'h11, 1'b0);
      run = 1'b0;
      repeat (5) @(negedge clk);
      run = 1'b1;
      d = randData();
      sendGood(1, d);
      ackPkt();

      for (int f = 0; f < 30; f++) begin
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h00;
            applyStimulus(g, 1'b0);
         end
         kind = int'($urandom_range(0, 3));
         len = int'($urandom_range(1, MAX_LEN));
         d = randData();
`ifndef UA_RX_CSUM_EN
         if (kind == 3) kind = 2;
`endif
         if (kind <= 1) begin
            sendGood(len, d);
            if ($urandom_range(0, 1) == 1) begin
               applyStimulus(8'($urandom_range(0, 255)), 1'b0);
               checkOutput("rand_overrun", int'(overrun), 1);
            end
            ackPkt();
         end else if (kind == 2) begin
            pushErr();
            applyStimulus(8'hA5, 1'b0);
            applyStimulus(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)), 1'b0);
            drainQueue();
         end else begin
`ifdef UA_RX_CSUM_EN
            sendBadCsum(len, d, 8'($urandom_range(1, 255)));
            drainQueue();
`endif
         end
      end

      drainQueue();
      applyStimulus(8'hA5, 1'b0);
      applyStimulus(8'h04, 1'b0);
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h02, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_rx_enable", int'(rx_enable), 0);
      checkOutput("midrst_pkt_valid", int'(pkt_valid), 0);
      checkOutput("midrst_pkt_len", int'(pkt_len), 0);
      checkOutput("midrst_pkt_err", int'(pkt_err), 0);
      checkOutput("midrst_overrun", int'(overrun), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("scoreboard_empty", expQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
